// File: rtl/async_fifo_tx_serializer_pkg.sv
// Shared types and header layout helpers for the write-domain FIFO message serializer.
package async_fifo_tx_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } tx_state_e;

    // Header beat: tag in the LSBs, clamped length in the MSBs.
    localparam int HDR_TAG_LSB = 0;

    function automatic int tx_len_width(input int nbeats);
        return $clog2(nbeats + 1);
    endfunction

    function automatic int hdr_len_lsb(input int dsize, input int lw);
        return dsize - lw;
    endfunction

endpackage

// File: rtl/async_fifo_tx_serializer_if.sv
// Message-in / beat-out bundle for the serializer; master is the serializer, slave its surroundings.
interface async_fifo_tx_serializer_if
    import async_fifo_tx_serializer_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int NBEATS = 4,
    parameter int LW     = tx_len_width(NBEATS)
);
    logic                     msg_valid;
    logic                     msg_ready;
    logic [DSIZE-LW-1:0]      msg_tag;
    logic [LW-1:0]            msg_len;
    logic [NBEATS*DSIZE-1:0]  msg_data;
    logic [DSIZE-1:0]         enq_bits;
    logic                     enq_valid;
    logic                     enq_ready;

    modport master (
        input  msg_valid, msg_tag, msg_len, msg_data, enq_ready,
        output msg_ready, enq_bits, enq_valid
    );

    modport slave (
        output msg_valid, msg_tag, msg_len, msg_data, enq_ready,
        input  msg_ready, enq_bits, enq_valid
    );
endinterface

// File: rtl/async_fifo_tx_serializer.sv
// Captures one wide message and streams it to the async FIFO enqueue port as a header beat
// followed by payload words, LSB word first, under valid/ready backpressure.
module async_fifo_tx_serializer
    import async_fifo_tx_serializer_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int NBEATS = 4,
    parameter int LW     = tx_len_width(NBEATS),
    parameter int CNTW   = 16
) (
    input  logic                          wclk,
    input  logic                          wrst,
    async_fifo_tx_serializer_if.master    bus,
    output logic                          busy,
    output logic                          len_err,
    output logic [CNTW-1:0]               msg_count
);

    localparam int              TAGW        = DSIZE - LW;
    localparam int              HDR_LEN_LSB = hdr_len_lsb(DSIZE, LW);
    localparam int              NWORDS      = 2 ** LW;
    localparam logic [LW-1:0]   MAX_LEN     = LW'(NBEATS);

    tx_state_e                  state_q;
    logic [NBEATS*DSIZE-1:0]    data_q;
    logic [LW-1:0]              len_q;
    logic [LW-1:0]              beat_idx_q;
    logic                       enq_valid_q;
    logic [DSIZE-1:0]           enq_bits_q;
    logic                       busy_q;
    logic                       len_err_q;
    logic [CNTW-1:0]            msg_count_q;

    logic                       over_d;
    logic [LW-1:0]              len_d;
    logic [LW-1:0]              next_idx_d;
    logic [DSIZE-1:0]           header_d;
    logic                       beat_xfer;
    logic                       last_beat;

    // Word table padded to a power of two so any LW-bit index stays in range.
    logic [DSIZE-1:0]           word_w [NWORDS];

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
            if (gi < NBEATS) begin : g_live
                assign word_w[gi] = data_q[gi*DSIZE +: DSIZE];
            end else begin : g_pad
                assign word_w[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        over_d     = (bus.msg_len > MAX_LEN);
        len_d      = over_d ? MAX_LEN : bus.msg_len;
        header_d   = '0;
        header_d[HDR_LEN_LSB +: LW]  = len_d;
        header_d[HDR_TAG_LSB +: TAGW] = bus.msg_tag;
        next_idx_d = beat_idx_q + 1'b1;
        beat_xfer  = enq_valid_q & bus.enq_ready;
        last_beat  = (beat_idx_q == len_q - 1'b1);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            len_q       <= '0;
            beat_idx_q  <= '0;
            enq_valid_q <= 1'b0;
            enq_bits_q  <= '0;
            busy_q      <= 1'b0;
            len_err_q   <= 1'b0;
            msg_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.msg_valid) begin
                        data_q      <= bus.msg_data;
                        len_q       <= len_d;
                        beat_idx_q  <= '0;
                        enq_bits_q  <= header_d;
                        enq_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_HDR;
                        if (over_d) begin
                            len_err_q <= 1'b1;
                        end
                    end
                end
                ST_HDR: begin
                    if (beat_xfer) begin
                        if (len_q == '0) begin
                            enq_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            msg_count_q <= msg_count_q + 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            enq_bits_q  <= word_w[0];
                            state_q     <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (beat_xfer) begin
                        if (last_beat) begin
                            enq_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            msg_count_q <= msg_count_q + 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            beat_idx_q  <= next_idx_d;
                            enq_bits_q  <= word_w[next_idx_d];
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    enq_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Ready depends on state alone so upstream never sees a path back from msg_valid.
    assign bus.msg_ready = (state_q == ST_IDLE);
    assign bus.enq_valid = enq_valid_q;
    assign bus.enq_bits  = enq_bits_q;
    assign busy          = busy_q;
    assign len_err       = len_err_q;
    assign msg_count     = msg_count_q;

endmodule
